// File: rtl/fp_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_seq_pkg : shared FSM states, flag indices and rounding helper (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fp_mul_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_NORM = 3'd2,
    ST_RND  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam int NFLAGS         = 4;
  localparam int FLAG_INVALID   = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_INEXACT   = 3;

  // Round-to-nearest-even increment decision; ties go to the even retained value.
  function automatic logic rne_round_up(input logic lsb, input logic guard,
                                        input logic round, input logic sticky);
    return guard & (round | sticky | lsb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_seq_if.sv
// ---------------------------------------------------------------------------
// fp_mul_seq_if : operand/result handshake bundle for fp_mul_seq (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface fp_mul_seq_if
  import fp_mul_seq_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  localparam int W = 1 + NEXP + NSIG;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      a;
  logic [W-1:0]      b;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      result;
  logic [NFLAGS-1:0] flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

`default_nettype wire

// File: rtl/fp_mul_seq_round.sv
// ---------------------------------------------------------------------------
// fp_mul_seq_round : RNE round unit for a normalised product, hidden bit removed (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_mul_seq_round
  import fp_mul_seq_pkg::*;
#(
  parameter int NSIG = 7
) (
  input  logic [2*NSIG:0]  prod,
  output logic [NSIG-1:0]  frac,
  output logic             carry,
  output logic             inexact
);

  logic [NSIG-1:0] retained;
  logic            guard;
  logic            round;
  logic            sticky;
  logic            up;

  assign retained = prod[2*NSIG:NSIG+1];
  assign guard    = prod[NSIG];
  assign round    = prod[NSIG-1];
  assign sticky   = |prod[NSIG-2:0];
  assign up       = rne_round_up(retained[0], guard, round, sticky);
  assign inexact  = guard | round | sticky;

  assign {carry, frac} = {1'b0, retained} + {{NSIG{1'b0}}, up};

endmodule

`default_nettype wire

// File: rtl/fp_mul_seq.sv
// ---------------------------------------------------------------------------
// fp_mul_seq : iterative bfloat multiplier sequencer, shift-add + shared round (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_mul_seq
  import fp_mul_seq_pkg::*;
#(
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus
);

  localparam int W    = 1 + NEXP + NSIG;
  localparam int SW   = NSIG + 1;
  localparam int PW   = 2 * NSIG + 2;
  localparam int EW   = NEXP + 2;
  localparam int CW   = $clog2(NSIG + 1);
  localparam int BIAS = 2 ** (NEXP - 1) - 1;

  localparam logic [NEXP-1:0]     EXP_ONES = '1;
  localparam logic [W-2:0]        QNAN_MAG = {EXP_ONES, 1'b1, {(NSIG-1){1'b0}}};
  localparam logic [W-2:0]        INF_MAG  = {EXP_ONES, {NSIG{1'b0}}};
  localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_OVF  = EW'(2 ** NEXP - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [CW-1:0]       CNT_LAST = CW'(NSIG);

  state_t                 state;
  logic                   sign;
  logic [PW-1:0]          mcand;
  logic [SW-1:0]          mplier;
  logic [PW-1:0]          product;
  logic signed [EW-1:0]   exp_acc;
  logic [CW-1:0]          counter;
  logic                   in_rdy;
  logic                   out_vld;
  logic [W-1:0]           res;
  logic [NFLAGS-1:0]      flg;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.result    = res;
  assign bus.flags     = flg;

  // Operand classification; exponent 0 is treated as zero (denormals flushed).
  logic [NEXP-1:0] exp_a, exp_b;
  logic [NSIG-1:0] frac_a, frac_b;
  logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic            in_sign, special;

  assign exp_a   = bus.a[W-2:NSIG];
  assign exp_b   = bus.b[W-2:NSIG];
  assign frac_a  = bus.a[NSIG-1:0];
  assign frac_b  = bus.b[NSIG-1:0];
  assign a_zero  = (exp_a == '0);
  assign b_zero  = (exp_b == '0);
  assign a_inf   = (exp_a == EXP_ONES) && (frac_a == '0);
  assign b_inf   = (exp_b == EXP_ONES) && (frac_b == '0);
  assign a_nan   = (exp_a == EXP_ONES) && (frac_a != '0);
  assign b_nan   = (exp_b == EXP_ONES) && (frac_b != '0);
  assign in_sign = bus.a[W-1] ^ bus.b[W-1];
  assign special = a_zero | b_zero | (exp_a == EXP_ONES) | (exp_b == EXP_ONES);

  logic [W-1:0]      special_result;
  logic [NFLAGS-1:0] special_flags;

  always_comb begin
    special_result = {in_sign, {(W-1){1'b0}}};
    special_flags  = '0;
    if (a_nan || b_nan) begin
      special_result = {1'b0, QNAN_MAG};
    end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
      special_result               = {1'b0, QNAN_MAG};
      special_flags[FLAG_INVALID]  = 1'b1;
    end else if (a_inf || b_inf) begin
      special_result = {in_sign, INF_MAG};
    end
  end

  logic signed [EW-1:0] exp_sum;
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - EXP_BIAS;

  logic [NSIG-1:0] rnd_frac;
  logic            rnd_carry;
  logic            rnd_inexact;

  fp_mul_seq_round #(.NSIG(NSIG)) u_round (
    .prod    (product[PW-2:0]),
    .frac    (rnd_frac),
    .carry   (rnd_carry),
    .inexact (rnd_inexact)
  );

  // Exponent after the rounding carry, then clamp to inf/zero on out-of-range.
  logic signed [EW-1:0] exp_rnd;
  logic [W-1:0]         fin_result;
  logic [NFLAGS-1:0]    fin_flags;

  assign exp_rnd = exp_acc + $signed({{(EW-1){1'b0}}, rnd_carry});

  always_comb begin
    fin_result              = {sign, exp_rnd[NEXP-1:0], rnd_frac};
    fin_flags               = '0;
    fin_flags[FLAG_INEXACT] = rnd_inexact;
    if (exp_rnd >= EXP_OVF) begin
      fin_result               = {sign, INF_MAG};
      fin_flags[FLAG_OVERFLOW] = 1'b1;
      fin_flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_rnd <= EXP_ZERO) begin
      fin_result                = {sign, {(W-1){1'b0}}};
      fin_flags[FLAG_UNDERFLOW] = 1'b1;
      fin_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      sign    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      exp_acc <= '0;
      counter <= '0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      res     <= '0;
      flg     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_rdy <= 1'b0;
            if (special) begin
              res     <= special_result;
              flg     <= special_flags;
              out_vld <= 1'b1;
              state   <= ST_DONE;
            end else begin
              sign    <= in_sign;
              mcand   <= PW'({1'b1, frac_a});
              mplier  <= {1'b1, frac_b};
              product <= '0;
              exp_acc <= exp_sum;
              counter <= '0;
              state   <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (mplier[0]) begin
            product <= product + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + 1'b1;
          if (counter == CNT_LAST) begin
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          // Product of two [1,2) significands is in [1,4); bring the leading 1 to the MSB.
          if (product[PW-1]) begin
            exp_acc <= exp_acc + EW'(1);
          end else begin
            product <= product << 1;
          end
          state <= ST_RND;
        end
        ST_RND: begin
          res     <= fin_result;
          flg     <= fin_flags;
          out_vld <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          out_vld <= 1'b0;
          in_rdy  <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_seq : randomized self-checking bench for fp_mul_seq (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_mul_seq;

  localparam int NEXP    = 8;
  localparam int NSIG    = 7;
  localparam int W       = 1 + NEXP + NSIG;
  localparam int BIAS    = 2 ** (NEXP - 1) - 1;
  localparam int EMAX    = 2 ** NEXP - 1;
  localparam int LAT_NRM = NSIG + 4;
  localparam int LAT_SPC = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fp_mul_seq_if #(.NEXP(NEXP), .NSIG(NSIG)) bus ();

  fp_mul_seq #(.NEXP(NEXP), .NSIG(NSIG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [W+3:0] exp_q[$];

  // Reference: {flags[3:0], result} from real-valued rules on integer significands.
  function automatic logic [W+3:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int ex, ey, fx, fy, e, sh;
    longint p, q, rem, half;
    logic s, xz, yz, xi, yi, xn, yn, inx;
    logic [W-1:0] r;
    logic [3:0] f;
    logic [W-1:0] qnan;
    qnan = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};
    s  = x[W-1] ^ y[W-1];
    ex = int'(x[W-2:NSIG]);  fx = int'(x[NSIG-1:0]);
    ey = int'(y[W-2:NSIG]);  fy = int'(y[NSIG-1:0]);
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == EMAX) && (fx == 0); yi = (ey == EMAX) && (fy == 0);
    xn = (ex == EMAX) && (fx != 0); yn = (ey == EMAX) && (fy != 0);
    f = 4'b0000;
    if (xn || yn) begin
      r = qnan;
    end else if ((xz && yi) || (xi && yz)) begin
      r = qnan; f = 4'b0001;
    end else if (xi || yi) begin
      r = {s, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (xz || yz) begin
      r = {s, {(W-1){1'b0}}};
    end else begin
      p = longint'(fx + 2 ** NSIG) * longint'(fy + 2 ** NSIG);
      e = ex + ey - BIAS;
      if (p >= (longint'(1) << (2 * NSIG + 1))) begin
        e  = e + 1;
        sh = NSIG + 1;
      end else begin
        sh = NSIG;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      inx  = (rem != 0);
      if ((rem > half) || ((rem == half) && (q % 2 == 1))) q = q + 1;
      if (q == (longint'(1) << (NSIG + 1))) begin
        q = longint'(1) << NSIG;
        e = e + 1;
      end
      if (e >= EMAX) begin
        r = {s, {NEXP{1'b1}}, {NSIG{1'b0}}}; f = 4'b1010;
      end else if (e <= 0) begin
        r = {s, {(W-1){1'b0}}}; f = 4'b1100;
      end else begin
        r = {s, e[NEXP-1:0], q[NSIG-1:0]}; f = {inx, 3'b000};
      end
    end
    return {f, r};
  endfunction

  function automatic logic is_special(input logic [W-1:0] x, input logic [W-1:0] y);
    int ex, ey;
    ex = int'(x[W-2:NSIG]);
    ey = int'(y[W-2:NSIG]);
    return (ex == 0) || (ey == 0) || (ex == EMAX) || (ey == EMAX);
  endfunction

  // Compare process: whenever a result is presented it must match the queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out_valid: got result=%h flags=%h, required no output", bus.result, bus.flags);
      end else begin
        if ({bus.flags, bus.result} !== exp_q[0]) begin
          miscompares++;
          $display("FAIL result: got result=%h flags=%h, required result=%h flags=%h",
                   bus.result, bus.flags, exp_q[0][W-1:0], exp_q[0][W+3:W]);
        end
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W+3:0] expv, input int hold, input int exp_lat);
    int lat;
    int wait_cnt;
    wait_cnt = 0;
    while (!bus.in_ready && wait_cnt < 50) begin
      @(posedge clk); #1; wait_cnt++;
    end
    vectors++;
    if (!bus.in_ready) begin
      miscompares++;
      $display("FAIL in_ready_timeout: got in_ready=%b, required 1", bus.in_ready);
      return;
    end
    bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (!bus.out_valid) begin
      miscompares++;
      $display("FAIL out_valid_timeout: got no out_valid in %0d cycles, required %0d", lat, exp_lat);
      exp_q.delete();
      return;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL latency: a=%h b=%h got %0d cycles, required %0d", x, y, lat, exp_lat);
    end
    // Stall the consumer; new operands offered meanwhile must be ignored.
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL in_ready_during_done: got %b, required 0", bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: got out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic pin_and_run(input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W+3:0] lit, input int hold);
    logic [W+3:0] m;
    m = ref_mul(x, y);
    vectors++;
    if (m !== lit) begin
      miscompares++;
      $display("FAIL model_pin: a=%h b=%h got %h, required %h", x, y, m, lit);
    end
    do_op(x, y, lit, hold, is_special(x, y) ? LAT_SPC : LAT_NRM);
  endtask

  function automatic logic [W-1:0] rand_operand();
    int sel;
    logic [NEXP-1:0] e;
    sel = $urandom_range(0, 9);
    if (sel == 0)      e = '0;
    else if (sel == 1) e = '1;
    else if (sel <= 3) return W'($urandom);
    else               e = NEXP'($urandom_range(60, 194));
    if (sel == 1 && $urandom_range(0, 1) == 0) return {1'(($urandom)), e, {NSIG{1'b0}}};
    return {1'($urandom), e, NSIG'($urandom)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    logic         stray;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;

    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== '0 || bus.flags !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h flg=%h, required 0/1/0000/0",
               bus.out_valid, bus.in_ready, bus.result, bus.flags);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    pin_and_run(16'h3F80, 16'h3F80, {4'h0, 16'h3F80}, 0);
    pin_and_run(16'h3FC0, 16'h3FC0, {4'h0, 16'h4010}, 5);
    pin_and_run(16'h3FFF, 16'h3FFF, {4'h8, 16'h407E}, 1);
    pin_and_run(16'h3F97, 16'h3FD9, {4'h8, 16'h4000}, 0);
    pin_and_run(16'h7F00, 16'h7F00, {4'hA, 16'h7F80}, 0);
    pin_and_run(16'h0080, 16'h0080, {4'hC, 16'h0000}, 2);
    pin_and_run(16'h0000, 16'h7F80, {4'h1, 16'h7FC0}, 0);
    pin_and_run(16'hFF80, 16'h3F80, {4'h0, 16'hFF80}, 0);
    pin_and_run(16'h7FC1, 16'h3F80, {4'h0, 16'h7FC0}, 3);
    pin_and_run(16'hBF80, 16'h3F80, {4'h0, 16'hBF80}, 0);

    // Abort an operation mid-multiply: nothing may ever be presented for it.
    bus.a = 16'h4040; bus.b = 16'h4000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== '0 || bus.flags !== '0) begin
      miscompares++;
      $display("FAIL mid_op_reset: got ov=%b ir=%b res=%h flg=%h, required 0/1/0000/0",
               bus.out_valid, bus.in_ready, bus.result, bus.flags);
    end
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL aborted_op_output: got out_valid=1 after reset, required 0");
    end
    pin_and_run(16'h4040, 16'h4000, {4'h0, 16'h40C0}, 0);

    for (int n = 0; n < 200; n++) begin
      x = rand_operand();
      y = rand_operand();
      do_op(x, y, ref_mul(x, y), $urandom_range(0, 3), is_special(x, y) ? LAT_SPC : LAT_NRM);
    end

    @(posedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
